// File: rtl/terrain_line_gen_if.sv
// Control and line-output bundle for the scrolling terrain-line generator.
// The master side (game logic or a bench) drives scroll/mode/seed controls;
// the slave side (the generator) returns the line, boundary pulse and gap count.
interface terrain_line_gen_if #(
  parameter int WIDTH        = 640,
  parameter int MAX_GAP_SEGS = 2
);
  localparam int GAP_W = $clog2(MAX_GAP_SEGS + 1);

  logic             en_i;
  logic [1:0]       mode_i;
  logic             seed_load_i;
  logic [15:0]      seed_i;
  logic [WIDTH-1:0] line_o;
  logic             seg_start_o;
  logic [GAP_W-1:0] gap_count_o;

  modport master (
    output en_i,
    output mode_i,
    output seed_load_i,
    output seed_i,
    input  line_o,
    input  seg_start_o,
    input  gap_count_o
  );

  modport slave (
    input  en_i,
    input  mode_i,
    input  seed_load_i,
    input  seed_i,
    output line_o,
    output seg_start_o,
    output gap_count_o
  );
endinterface

// File: rtl/terrain_line_gen.sv
// Scrolling terrain-line generator: shifts a WIDTH-bit line by one column per
// enabled clock, filling new columns with a segment bit held for SEG_LEN columns.
// Segment bits come from a seedable 16-bit Fibonacci LFSR (RANDOM) or from the
// SOLID / ALTERNATE modes; a gap limiter forces a solid segment after
// MAX_GAP_SEGS consecutive empty ones so the terrain is always crossable.
module terrain_line_gen #(
  parameter int          WIDTH        = 640,
  parameter int          SEG_LEN      = 80,
  parameter int          MAX_GAP_SEGS = 2,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  terrain_line_gen_if.slave bus
);

  localparam int CNT_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
  localparam int GAP_W = $clog2(MAX_GAP_SEGS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SEG_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP_SEGS);

  // A zero seed would lock the LFSR, so fall back to 1 if SEED is misconfigured.
  localparam logic [15:0] SAFE_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;

  localparam logic [1:0] MODE_RANDOM    = 2'b00;
  localparam logic [1:0] MODE_SOLID     = 2'b01;
  localparam logic [1:0] MODE_ALTERNATE = 2'b10;
  localparam logic [1:0] MODE_FREEZE    = 2'b11;

  logic [WIDTH-1:0] line_q,      line_d;
  logic             cur_bit_q,   cur_bit_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [15:0]      lfsr_q,      lfsr_d;
  logic [GAP_W-1:0] gap_run_q,   gap_run_d;
  logic             seg_start_q, seg_start_d;

  logic             shift;
  logic             boundary;
  logic             next_bit;
  logic             lfsr_fb;
  logic [15:0]      load_value;

  // Decide whether this cycle scrolls and whether it closes the current segment.
  always_comb begin
    shift    = bus.en_i && (bus.mode_i != MODE_FREEZE);
    boundary = shift && (cnt_q == CNT_LAST);
  end

  // Pick the bit for the next segment; RANDOM uses the pre-step LFSR value and
  // is overridden to a solid column once the gap run has hit its limit.
  always_comb begin
    next_bit = 1'b1;
    case (bus.mode_i)
      MODE_RANDOM:    next_bit = (gap_run_q == GAP_LIMIT) ? 1'b1 : lfsr_q[0];
      MODE_SOLID:     next_bit = 1'b1;
      MODE_ALTERNATE: next_bit = ~cur_bit_q;
      default:        next_bit = cur_bit_q;
    endcase
  end

  // Fibonacci feedback taps and the sanitised seed-load value.
  always_comb begin
    lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    load_value = (bus.seed_i == 16'h0000) ? SAFE_SEED : bus.seed_i;
  end

  // Next-state logic: scroll, count columns, and update segment state on boundaries.
  always_comb begin
    line_d      = line_q;
    cur_bit_d   = cur_bit_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    gap_run_d   = gap_run_q;
    seg_start_d = 1'b0;

    if (shift) begin
      line_d = {line_q[WIDTH-2:0], cur_bit_q};
      if (boundary) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (boundary) begin
      cur_bit_d   = next_bit;
      lfsr_d      = {lfsr_q[14:0], lfsr_fb};
      gap_run_d   = next_bit ? '0 : (gap_run_q + GAP_W'(1));
      seg_start_d = 1'b1;
    end

    // A seed load wins over the boundary step; next_bit above already used the old value.
    if (bus.seed_load_i) begin
      lfsr_d = load_value;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      line_q      <= '1;
      cur_bit_q   <= 1'b1;
      cnt_q       <= '0;
      lfsr_q      <= SAFE_SEED;
      gap_run_q   <= '0;
      seg_start_q <= 1'b0;
    end else begin
      line_q      <= line_d;
      cur_bit_q   <= cur_bit_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      gap_run_q   <= gap_run_d;
      seg_start_q <= seg_start_d;
    end
  end

  assign bus.line_o      = line_q;
  assign bus.seg_start_o = seg_start_q;
  assign bus.gap_count_o = gap_run_q;

endmodule

// File: tb/tb_terrain_line_gen.sv
// Directed and soak bench for terrain_line_gen (WIDTH=16, SEG_LEN=4, MAX_GAP_SEGS=2).
module tb_terrain_line_gen;

  localparam int          WIDTH        = 16;
  localparam int          SEG_LEN      = 4;
  localparam int          MAX_GAP_SEGS = 2;
  localparam logic [15:0] SEED         = 16'hACE1;

  localparam logic [1:0] M_RANDOM = 2'b00;
  localparam logic [1:0] M_SOLID  = 2'b01;
  localparam logic [1:0] M_ALT    = 2'b10;
  localparam logic [1:0] M_FREEZE = 2'b11;

  logic clk_i;
  logic reset_i;

  int check_count;
  int pass_count;

  terrain_line_gen_if #(.WIDTH(WIDTH), .MAX_GAP_SEGS(MAX_GAP_SEGS)) bus ();

  terrain_line_gen #(
    .WIDTH       (WIDTH),
    .SEG_LEN     (SEG_LEN),
    .MAX_GAP_SEGS(MAX_GAP_SEGS),
    .SEED        (SEED)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      pass_count++;
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic [1:0] mode,
                                input logic seed_load, input logic [15:0] seed);
    bus.en_i        = en;
    bus.mode_i      = mode;
    bus.seed_load_i = seed_load;
    bus.seed_i      = seed;
  endtask

  // Advance n rising edges; outputs are then sampled 1 unit after the edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    step(1);
    reset_i = 1'b1;
  endtask

  // Soak model state
  logic [15:0] m_line;
  logic [15:0] m_lfsr;
  logic        m_cur;
  int          m_cnt;
  int          m_gap;
  logic        m_shift;
  logic        m_bnd;
  logic        m_nb;
  logic        m_fb;

  initial begin
    logic        en_r;
    logic [1:0]  mode_r;
    logic        sl_r;
    logic [15:0] sd_r;
    logic        solid_ok;
    logic        first_bit;
    logic        uniform;
    int          seg_col;
    int          zero_run;
    int          segs;
    int          cycles;

    check_count = 0;
    pass_count  = 0;
    reset_i     = 1'b1;
    apply_stimulus(1'b1, M_ALT, 1'b0, 16'h0000);

    // Reset held for 3 cycles with en high
    reset_i = 1'b0;
    step(3);
    check_output("reset_line", 32'(bus.line_o), 32'h0000FFFF);
    check_output("reset_seg_start", 32'(bus.seg_start_o), 32'd0);
    check_output("reset_gap", 32'(bus.gap_count_o), 32'd0);
    reset_i = 1'b1;

    // ALTERNATE from reset
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (i == 4 || i == 8 || i == 12 || i == 16)
        check_output($sformatf("alt_seg_start_%0d", i), 32'(bus.seg_start_o), 32'd1);
      if (i == 5)  check_output("alt_seg_start_5", 32'(bus.seg_start_o), 32'd0);
      if (i == 4)  check_output("alt_gap_4", 32'(bus.gap_count_o), 32'd1);
      if (i == 8)  check_output("alt_line_8", 32'(bus.line_o), 32'h0000FFF0);
      if (i == 16) check_output("alt_line_16", 32'(bus.line_o), 32'h0000F0F0);
    end

    // Mid-run reset returns to all ones
    do_reset();
    check_output("midrun_reset_line", 32'(bus.line_o), 32'h0000FFFF);
    check_output("midrun_reset_seg_start", 32'(bus.seg_start_o), 32'd0);

    // SOLID for 1000 enabled cycles
    apply_stimulus(1'b1, M_SOLID, 1'b0, 16'h0000);
    solid_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (bus.line_o !== 16'hFFFF || bus.gap_count_o !== 2'd0) solid_ok = 1'b0;
    end
    check_output("solid_all_ones_1000", 32'(solid_ok), 32'd1);
    check_output("solid_gap", 32'(bus.gap_count_o), 32'd0);

    // Switch to ALTERNATE, then freeze mid-segment
    apply_stimulus(1'b1, M_ALT, 1'b0, 16'h0000);
    step(4);
    check_output("freeze_pre_seg_start", 32'(bus.seg_start_o), 32'd1);
    check_output("freeze_pre_gap", 32'(bus.gap_count_o), 32'd1);
    step(1);
    check_output("freeze_pre_line", 32'(bus.line_o), 32'h0000FFFE);
    apply_stimulus(1'b1, M_FREEZE, 1'b0, 16'h0000);
    step(20);
    check_output("freeze_line", 32'(bus.line_o), 32'h0000FFFE);
    check_output("freeze_seg_start", 32'(bus.seg_start_o), 32'd0);
    apply_stimulus(1'b0, M_ALT, 1'b0, 16'h0000);
    step(5);
    check_output("en_low_line", 32'(bus.line_o), 32'h0000FFFE);
    apply_stimulus(1'b1, M_ALT, 1'b0, 16'h0000);
    step(2);
    check_output("resume_line_2", 32'(bus.line_o), 32'h0000FFF8);
    check_output("resume_seg_start_2", 32'(bus.seg_start_o), 32'd0);
    step(1);
    check_output("resume_line_3", 32'(bus.line_o), 32'h0000FFF0);
    check_output("resume_seg_start_3", 32'(bus.seg_start_o), 32'd1);

    // Gap limiter: seed 0002 gives bits 0, 0, then forced 1
    do_reset();
    apply_stimulus(1'b0, M_RANDOM, 1'b1, 16'h0002);
    step(1);
    apply_stimulus(1'b1, M_RANDOM, 1'b0, 16'h0000);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (i == 4) begin
        check_output("gap_seg_start_4", 32'(bus.seg_start_o), 32'd1);
        check_output("gap_count_4", 32'(bus.gap_count_o), 32'd1);
        check_output("gap_line_4", 32'(bus.line_o), 32'h0000FFFF);
      end
      if (i == 8)  check_output("gap_count_8", 32'(bus.gap_count_o), 32'd2);
      if (i == 12) begin
        check_output("gap_count_12", 32'(bus.gap_count_o), 32'd0);
        check_output("gap_line_12", 32'(bus.line_o), 32'h0000FF00);
      end
      if (i == 16) check_output("gap_line_16", 32'(bus.line_o), 32'h0000F00F);
    end

    // Seed 0 is replaced by SEED: first random segment is 1
    do_reset();
    apply_stimulus(1'b0, M_RANDOM, 1'b1, 16'h0002);
    step(1);
    apply_stimulus(1'b0, M_RANDOM, 1'b1, 16'h0000);
    step(1);
    apply_stimulus(1'b1, M_RANDOM, 1'b0, 16'h0000);
    step(4);
    check_output("seed0_seg_start", 32'(bus.seg_start_o), 32'd1);
    check_output("seed0_gap_4", 32'(bus.gap_count_o), 32'd0);
    step(4);
    check_output("seed0_line_8", 32'(bus.line_o), 32'h0000FFFF);
    check_output("seed0_gap_8", 32'(bus.gap_count_o), 32'd0);

    // Random soak in RANDOM mode against a reference model
    do_reset();
    m_line   = 16'hFFFF;
    m_lfsr   = SEED;
    m_cur    = 1'b1;
    m_cnt    = 0;
    m_gap    = 0;
    seg_col  = 0;
    zero_run = 0;
    first_bit = 1'b1;
    uniform  = 1'b1;
    segs     = 0;
    cycles   = 0;
    while (segs < 10000 && cycles < 70000) begin
      en_r   = ($urandom_range(0, 15) != 0);
      mode_r = ($urandom_range(0, 15) == 0) ? M_FREEZE : M_RANDOM;
      sl_r   = ($urandom_range(0, 63) == 0);
      sd_r   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      apply_stimulus(en_r, mode_r, sl_r, sd_r);

      m_shift = en_r && (mode_r != M_FREEZE);
      m_bnd   = m_shift && (m_cnt == SEG_LEN - 1);
      m_nb    = (m_gap == MAX_GAP_SEGS) ? 1'b1 : m_lfsr[0];
      m_fb    = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];

      step(1);
      cycles++;

      if (m_shift) begin
        m_line = {m_line[14:0], m_cur};
        m_cnt  = m_bnd ? 0 : m_cnt + 1;
        seg_col++;
        if (seg_col == 1) first_bit = bus.line_o[0];
        else if (bus.line_o[0] !== first_bit) uniform = 1'b0;
      end
      if (m_bnd) begin
        m_cur  = m_nb;
        m_gap  = m_nb ? 0 : m_gap + 1;
        m_lfsr = {m_lfsr[14:0], m_fb};
        segs++;
      end
      if (sl_r) m_lfsr = (sd_r == 16'h0000) ? SEED : sd_r;

      check_output("soak_line", 32'(bus.line_o), 32'(m_line));
      check_output("soak_seg_start", 32'(bus.seg_start_o), 32'(m_bnd));
      check_output("soak_gap", 32'(bus.gap_count_o), 32'(m_gap));
      if (m_bnd) begin
        check_output("soak_seg_shape", {uniform, 31'(seg_col)}, {1'b1, 31'(SEG_LEN)});
        zero_run = (first_bit == 1'b0) ? zero_run + 1 : 0;
        check_output("soak_zero_run_ok", 32'(zero_run <= MAX_GAP_SEGS), 32'd1);
        check_output("soak_gap_le_max", 32'(bus.gap_count_o <= 2'(MAX_GAP_SEGS)), 32'd1);
        seg_col = 0;
        uniform = 1'b1;
      end
    end
    check_output("soak_completed", 32'(segs), 32'd10000);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
